multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RV32I datapath variant, and the producer of the 2-bit alu_op consumed by the ALU control decoder. It sequences fetch, decode, execute, memory and writeback per instruction, drives all datapath mux selects and write enables, and handshakes with a shared instruction/data memory. It supports R-type, I-type ALU, lw, sw and beq; any other opcode traps.

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_output_decoder.sv | 72 +++++++
 rtl/multicycle_control.sv | 105 ++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation codes and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU control decoder interprets 10 as "look at funct3/funct7".
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/ctrl_output_decoder.sv
// Combinational control-word decode from the FSM state; the handshake and
// branch enables are Mealy on mem_ready and zero.
module ctrl_output_decoder
  import ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_memReady,
  input  logic   i_zero,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.alu_src_a = SRC_A_PC;
        o_ctrl.alu_src_b = SRC_B_FOUR;
        o_ctrl.alu_op    = ALU_OP_ADD;
        o_ctrl.ir_write  = i_memReady;
        o_ctrl.pc_write  = i_memReady;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a = SRC_A_OLD_PC;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_RS2;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.iord      = 1'b1;
        o_ctrl.mdr_write = i_memReady;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      // Branch target was parked in ALUOut during DECODE; the ALU now compares.
      S_BRANCH: begin
        o_ctrl.alu_src_a = SRC_A_RS1;
        o_ctrl.alu_src_b = SRC_B_RS2;
        o_ctrl.alu_op    = ALU_OP_SUB;
        o_ctrl.pc_src    = 1'b1;
        o_ctrl.pc_write  = i_zero;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences each
// instruction, tracks the sticky illegal-opcode flag and counts retirements.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_retire;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;
  ctrl_t            w_gated;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_nextState = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_R)                               w_nextState = S_EXEC_R;
        else if (opcode == OPC_I)                          w_nextState = S_EXEC_I;
        else if (opcode == OPC_LOAD || opcode == OPC_STORE) w_nextState = S_MEM_ADDR;
        else if (opcode == OPC_BRANCH)                     w_nextState = S_BRANCH;
        else                                               w_nextState = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: w_nextState = S_ALU_WB;
      S_MEM_ADDR: w_nextState = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: if (mem_ready) w_nextState = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          w_retire    = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH: begin
        w_retire    = 1'b1;
        w_nextState = S_FETCH;
      end
      S_TRAP:  w_nextState = S_TRAP;
      default: w_nextState = S_FETCH;
    endcase
  end

  ctrl_output_decoder u_decoder (
    .i_state    (r_state),
    .i_memReady (mem_ready),
    .i_zero     (zero),
    .o_ctrl     (w_ctrl)
  );

  // Holding reset drops any in-flight memory request immediately.
  assign w_gated    = rst_n ? w_ctrl : '0;

  assign mem_req    = w_gated.mem_req;
  assign mem_we     = w_gated.mem_we;
  assign iord       = w_gated.iord;
  assign ir_write   = w_gated.ir_write;
  assign mdr_write  = w_gated.mdr_write;
  assign pc_write   = w_gated.pc_write;
  assign pc_src     = w_gated.pc_src;
  assign alu_src_a  = w_gated.alu_src_a;
  assign alu_src_b  = w_gated.alu_src_b;
  assign alu_op     = w_gated.alu_op;
  assign reg_write  = w_gated.reg_write;
  assign mem_to_reg = w_gated.mem_to_reg;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues one expected
// control word per cycle, the monitor pops and compares on the falling edge.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [14:0] MREQ   = 15'h4000;
  localparam logic [14:0] MWE    = 15'h2000;
  localparam logic [14:0] IORD   = 15'h1000;
  localparam logic [14:0] IRW    = 15'h0800;
  localparam logic [14:0] MDRW   = 15'h0400;
  localparam logic [14:0] PCW    = 15'h0200;
  localparam logic [14:0] PCSRC  = 15'h0100;
  localparam logic [14:0] A_RS1  = 15'h0080;
  localparam logic [14:0] A_OLD  = 15'h0040;
  localparam logic [14:0] B_IMM  = 15'h0020;
  localparam logic [14:0] B_4    = 15'h0010;
  localparam logic [14:0] OP_FN  = 15'h0008;
  localparam logic [14:0] OP_SUB = 15'h0004;
  localparam logic [14:0] RW     = 15'h0002;
  localparam logic [14:0] M2R    = 15'h0001;

  localparam logic [6:0] ADD_OP = 7'b0110011;
  localparam logic [6:0] ADDI_OP = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;
  localparam logic [6:0] BAD_OP = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = '0;
  logic             zero = 1'b0;
  logic             memReady = 1'b0;
  logic             memReq, memWe, iord, irWrite, mdrWrite, pcWrite, pcSrc;
  logic [1:0]       aluSrcA, aluSrcB, aluOp;
  logic             regWrite, memToReg, illegal;
  logic [CNT_W-1:0] retired;
  logic [14:0]      actCtl;

  typedef struct {
    logic [14:0]      ctl;
    logic             chk;
    logic             ill;
    logic [CNT_W-1:0] ret;
    int               step;
  } exp_t;

  exp_t             expQ[$];
  int               total = 0;
  int               bad = 0;
  int               stepNo = 0;
  logic [CNT_W-1:0] expRet = '0;
  logic             expIll = 1'b0;

  always #5 clk = ~clk;

  multicycle_control #(.OPC_W(7), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (memReady),
    .mem_req    (memReq),
    .mem_we     (memWe),
    .iord       (iord),
    .ir_write   (irWrite),
    .mdr_write  (mdrWrite),
    .pc_write   (pcWrite),
    .pc_src     (pcSrc),
    .alu_src_a  (aluSrcA),
    .alu_src_b  (aluSrcB),
    .alu_op     (aluOp),
    .reg_write  (regWrite),
    .mem_to_reg (memToReg),
    .illegal    (illegal),
    .retired    (retired)
  );

  assign actCtl = {memReq, memWe, iord, irWrite, mdrWrite, pcWrite, pcSrc,
                   aluSrcA, aluSrcB, aluOp, regWrite, memToReg};

  // One call drives one clock cycle and queues what the DUT must show in it.
  task automatic applyStimulus(input logic rstN, input logic [6:0] opc,
                               input logic z, input logic rdy,
                               input logic [14:0] ctl, input logic chk,
                               input logic retire);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rstN;
    opcode   = opc;
    zero     = z;
    memReady = rdy;
    e.ctl  = ctl;
    e.chk  = chk;
    e.ill  = expIll;
    e.ret  = expRet;
    e.step = stepNo;
    stepNo++;
    expQ.push_back(e);
    if (retire) expRet = expRet + 1'b1;
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (actCtl !== e.ctl) begin
      bad++;
      $display("[TB] FAIL ctl step=%0d got=%h want=%h", e.step, actCtl, e.ctl);
    end
    if (e.chk) begin
      total++;
      if (illegal !== e.ill) begin
        bad++;
        $display("[TB] FAIL illegal step=%0d got=%b want=%b", e.step, illegal, e.ill);
      end
      total++;
      if (retired !== e.ret) begin
        bad++;
        $display("[TB] FAIL retired step=%0d got=%0d want=%0d", e.step, retired, e.ret);
      end
    end
  endtask

  task automatic runAlu(input logic [6:0] opc, input logic [14:0] execCtl);
    applyStimulus(1'b1, opc, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, opc, 1'b0, 1'b1, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, opc, 1'b0, 1'b1, execCtl, 1'b1, 1'b0);
    applyStimulus(1'b1, opc, 1'b0, 1'b1, RW, 1'b1, 1'b1);
  endtask

  task automatic runLoad(input int fetchWaits, input int readWaits);
    for (int i = 0; i < fetchWaits; i++)
      applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, MREQ | B_4, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, A_RS1 | B_IMM, 1'b1, 1'b0);
    for (int i = 0; i < readWaits; i++)
      applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, MREQ | IORD, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, MREQ | IORD | MDRW, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, RW | M2R, 1'b1, 1'b1);
  endtask

  task automatic runStore(input int writeWaits);
    applyStimulus(1'b1, SW_OP, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, SW_OP, 1'b0, 1'b0, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, SW_OP, 1'b0, 1'b0, A_RS1 | B_IMM, 1'b1, 1'b0);
    for (int i = 0; i < writeWaits; i++)
      applyStimulus(1'b1, SW_OP, 1'b0, 1'b0, MREQ | MWE | IORD, 1'b1, 1'b0);
    applyStimulus(1'b1, SW_OP, 1'b0, 1'b1, MREQ | MWE | IORD, 1'b1, 1'b1);
  endtask

  task automatic runBranch(input logic z);
    applyStimulus(1'b1, BEQ_OP, z, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, BEQ_OP, z, 1'b0, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, BEQ_OP, z, 1'b1, A_RS1 | OP_SUB | PCSRC | (z ? PCW : 15'h0), 1'b1, 1'b1);
  endtask

  // Monitor: compares the DUT against the queued expectation each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 15'h0, 1'b0, 1'b0);
    expRet = '0;
    expIll = 1'b0;

    runAlu(ADD_OP, A_RS1 | OP_FN);
    runAlu(ADDI_OP, A_RS1 | B_IMM | OP_FN);
    runLoad(2, 2);
    runStore(0);
    runStore(1);
    runBranch(1'b1);
    runBranch(1'b0);

    // Reset lands while a load is waiting on memory.
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, A_RS1 | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, MREQ | IORD, 1'b1, 1'b0);
    applyStimulus(1'b0, LW_OP, 1'b0, 1'b0, 15'h0, 1'b1, 1'b0);
    expRet = '0;
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, MREQ | B_4, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, A_RS1 | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b1, MREQ | IORD | MDRW, 1'b1, 1'b0);
    applyStimulus(1'b1, LW_OP, 1'b0, 1'b0, RW | M2R, 1'b1, 1'b1);

    // Illegal opcode: trap, stay dead for 20 cycles, recover only by reset.
    applyStimulus(1'b1, BAD_OP, 1'b0, 1'b1, MREQ | B_4 | IRW | PCW, 1'b1, 1'b0);
    applyStimulus(1'b1, BAD_OP, 1'b0, 1'b1, A_OLD | B_IMM, 1'b1, 1'b0);
    applyStimulus(1'b1, BAD_OP, 1'b1, 1'b1, 15'h0, 1'b1, 1'b0);
    expIll = 1'b1;
    for (int i = 0; i < 19; i++)
      applyStimulus(1'b1, (i % 2 == 0) ? ADD_OP : BAD_OP, 1'b1, 1'b1, 15'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, BAD_OP, 1'b1, 1'b1, 15'h0, 1'b1, 1'b0);
    expIll = 1'b0;
    expRet = '0;

    // Sixteen retirements on a 4-bit counter must wrap back to zero.
    for (int i = 0; i < 16; i++)
      runBranch(i[0]);
    runAlu(ADD_OP, A_RS1 | OP_FN);
    applyStimulus(1'b1, ADD_OP, 1'b0, 1'b0, MREQ | B_4, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0 pending entries", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
